// File: rtl/core_sequencer.sv
// core_sequencer: operating-mode control, button conditioning and
// one-hot stage sequencing for the 32-entry single-issue core.
module core_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int DB_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_load,
  input  logic              sw_run,
  input  logic              sw_step,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              halt_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              mem_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [4:0]        stage,
  output logic [1:0]        mode,
  output logic              load_done,
  output logic              retire
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    M_LOAD = 2'b00,
    M_RUN  = 2'b01,
    M_STEP = 2'b10,
    M_HALT = 2'b11
  } mode_e;

  localparam logic [4:0] S_IF  = 5'b00001;
  localparam logic [4:0] S_ID  = 5'b00010;
  localparam logic [4:0] S_EX  = 5'b00100;
  localparam logic [4:0] S_MEM = 5'b01000;
  localparam logic [4:0] S_WB  = 5'b10000;

  logic [1:0] rst_ff;
  logic       rst_i_n;

  // Async assert, clock-synchronized release of the internal reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_ff <= 2'b00;
    else        rst_ff <= {rst_ff[0], 1'b1};
  end

  assign rst_i_n = rst_ff[1];

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] lvl;
  logic [2:0] lvl_q;
  logic [2:0] ev;

  assign raw = {sw_step, sw_run, sw_load};

  // Two-flop synchronizers and the edge-detect history
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl_q <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_q <= lvl;
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            acc;

    // Accept a new level only after DB_CYCLES identical samples
    always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
        cnt <= '0;
        acc <= 1'b0;
      end else if (sync2[b] == acc) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        cnt <= '0;
        acc <= sync2[b];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign lvl[b] = acc;
  end

  assign ev = lvl & ~lvl_q;

  logic ev_load;
  logic ev_run;
  logic ev_step;

  assign ev_load = ev[0];
  assign ev_run  = ev[1];
  assign ev_step = ev[2];

  mode_e             mode_q, mode_d;
  logic [4:0]        stage_q, stage_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              done_q, done_d;
  logic              halt_q, halt_d;
  logic              br_q, br_d;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      mode_q  <= M_LOAD;
      stage_q <= '0;
      pc_q    <= '0;
      wptr_q  <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      stage_q <= stage_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      halt_q  <= halt_d;
      br_q    <= br_d;
    end
  end

  // Mode transitions, loader pointer and stage sequencing
  always_comb begin
    mode_d  = mode_q;
    stage_d = stage_q;
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    tgt_d   = tgt_q;
    done_d  = done_q;
    halt_d  = halt_q;
    br_d    = br_q;
    if (ev_load) begin
      mode_d  = M_LOAD;
      stage_d = '0;
      pc_d    = '0;
      wptr_d  = '0;
      done_d  = 1'b0;
      halt_d  = 1'b0;
      br_d    = 1'b0;
      tgt_d   = '0;
    end else begin
      unique case (mode_q)
        M_LOAD: begin
          if (ld_valid) begin
            wptr_d = wptr_q + 1'b1;
            if (ld_last) done_d = 1'b1;
          end
          if (ev_run) begin
            mode_d = M_RUN;
            pc_d   = '0;
          end else if (ev_step) begin
            mode_d = M_STEP;
          end
        end
        M_HALT: begin
          if (ev_run)       mode_d = M_RUN;
          else if (ev_step) mode_d = M_STEP;
        end
        M_RUN, M_STEP: begin
          if (ev_run) mode_d = M_RUN;
          if (stage_q == '0) begin
            stage_d = S_IF;
          end else begin
            unique case (1'b1)
              stage_q[0]: begin
                halt_d  = 1'b0;
                br_d    = 1'b0;
                stage_d = S_ID;
              end
              stage_q[1]: begin
                halt_d  = halt_req;
                stage_d = S_EX;
              end
              stage_q[2]: begin
                br_d    = br_taken;
                tgt_d   = br_target;
                stage_d = S_MEM;
              end
              stage_q[3]: begin
                if (mem_ready) stage_d = S_WB;
              end
              stage_q[4]: begin
                pc_d = br_q ? tgt_q : pc_q + 1'b1;
                if (halt_q || mode_d == M_STEP) begin
                  mode_d  = M_HALT;
                  stage_d = '0;
                end else begin
                  stage_d = S_IF;
                end
              end
              default: stage_d = '0;
            endcase
          end
        end
        default: mode_d = M_LOAD;
      endcase
    end
  end

  assign imem_we    = (mode_q == M_LOAD) & ld_valid;
  assign imem_waddr = wptr_q;
  assign imem_wdata = ld_data;
  assign pc         = pc_q;
  assign stage      = stage_q;
  assign mode       = mode_q;
  assign load_done  = done_q;
  assign retire     = stage_q[4];

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed scoreboard bench for core_sequencer
// (loader writes and retires are checked by a decoupled monitor).
module tb_core_sequencer;

  localparam int DB = 4;

  logic        clk;
  logic        rst_n;
  logic        sw_load;
  logic        sw_run;
  logic        sw_step;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        halt_req;
  logic        br_taken;
  logic [4:0]  br_target;
  logic        mem_ready;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [4:0]  pc;
  logic [4:0]  stage;
  logic [1:0]  mode;
  logic        load_done;
  logic        retire;

  int checks = 0;
  int errors = 0;
  int n_ret  = 0;
  int rb;

  logic [4:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [4:0]  rp_q[$];

  core_sequencer #(.ADDR_W(5), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_load    (sw_load),
    .sw_run     (sw_run),
    .sw_step    (sw_step),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .halt_req   (halt_req),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .mem_ready  (mem_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .pc         (pc),
    .stage      (stage),
    .mode       (mode),
    .load_done  (load_done),
    .retire     (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: pop expected writes / retires whenever the DUT presents one
  always @(negedge clk) begin
    logic [4:0]  ea;
    logic [31:0] ed;
    if (imem_we) begin
      checks++;
      if (wa_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: addr %0d data %h, none expected",
                 imem_waddr, imem_wdata);
      end else begin
        ea = wa_q.pop_front();
        ed = wd_q.pop_front();
        if (imem_waddr !== ea || imem_wdata !== ed) begin
          errors++;
          $display("FAIL wr: got %0d/%h expected %0d/%h",
                   imem_waddr, imem_wdata, ea, ed);
        end
      end
    end
    if (retire) begin
      n_ret++;
      checks++;
      if (rp_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: pc %0d, none expected", pc);
      end else begin
        ea = rp_q.pop_front();
        if (pc !== ea) begin
          errors++;
          $display("FAIL retire_pc: got %0d expected %0d", pc, ea);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: sw_load = v;
      1: sw_run  = v;
      default: sw_step = v;
    endcase
  endtask

  task automatic press(input int b, input logic [1:0] tgt);
    set_btn(b, 1'b1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mode == tgt) break;
    end
    chk("press_mode", 32'(mode), 32'(tgt));
  endtask

  task automatic release_all();
    sw_load = 1'b0;
    sw_run  = 1'b0;
    sw_step = 1'b0;
    repeat (DB + 8) tick();
  endtask

  task automatic run_instr(input logic [4:0] epc, input int stall,
                           input logic br, input logic [4:0] tgt,
                           input logic hlt);
    chk("if_stage", 32'(stage), 32'h01);
    chk("if_pc", 32'(pc), 32'(epc));
    rp_q.push_back(epc);
    tick();
    chk("id_stage", 32'(stage), 32'h02);
    halt_req = hlt;
    tick();
    halt_req = 1'b0;
    chk("ex_stage", 32'(stage), 32'h04);
    br_taken  = br;
    br_target = tgt;
    tick();
    br_taken  = 1'b0;
    br_target = '0;
    mem_ready = (stall == 0);
    for (int k = 0; k < stall; k++) begin
      chk("mem_hold", 32'(stage), 32'h08);
      tick();
    end
    mem_ready = 1'b1;
    chk("mem_stage", 32'(stage), 32'h08);
    tick();
    chk("wb_stage", 32'(stage), 32'h10);
    chk("wb_retire", 32'(retire), 32'h1);
    tick();
  endtask

  logic [31:0] w3 [3];
  logic [4:0]  st_exp [6];

  initial begin
    w3[0] = 32'h1111_0001;
    w3[1] = 32'h2222_0002;
    w3[2] = 32'h3333_0003;
    st_exp[0] = 5'h04;
    st_exp[1] = 5'h08;
    st_exp[2] = 5'h10;
    st_exp[3] = 5'h01;
    st_exp[4] = 5'h02;
    st_exp[5] = 5'h04;
    rst_n = 1'b1;
    sw_load = 1'b0;
    sw_run = 1'b0;
    sw_step = 1'b0;
    ld_valid = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    halt_req = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_mode", 32'(mode), 32'h0);
    chk("rst_stage", 32'(stage), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_imem_we", 32'(imem_we), 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("load_mode", 32'(mode), 32'h0);

    for (int i = 0; i < 3; i++) begin
      wa_q.push_back(5'(i));
      wd_q.push_back(w3[i]);
      ld_valid = 1'b1;
      ld_data  = w3[i];
      ld_last  = (i == 2);
      tick();
      if (i == 1) chk("load_done_early", 32'(load_done), 32'h0);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("load_done", 32'(load_done), 32'h1);

    press(1, 2'b01);
    chk("run_first_stage", 32'(stage), 32'h0);
    chk("run_first_pc", 32'(pc), 32'h0);
    tick();
    run_instr(5'd0, 0, 1'b0, 5'd0, 1'b0);
    run_instr(5'd1, 3, 1'b0, 5'd0, 1'b0);
    run_instr(5'd2, 0, 1'b1, 5'd7, 1'b0);
    run_instr(5'd7, 0, 1'b0, 5'd0, 1'b1);
    chk("halt_mode", 32'(mode), 32'h3);
    chk("halt_stage", 32'(stage), 32'h0);
    chk("halt_pc", 32'(pc), 32'h8);
    chk("retire_count", 32'(n_ret), 32'h4);
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    tick();
    chk("we_outside_load", 32'(imem_we), 32'h0);
    ld_valid = 1'b0;
    repeat (3) tick();
    chk("halt_pc_hold", 32'(pc), 32'h8);
    chk("halt_stage_hold", 32'(stage), 32'h0);

    release_all();
    rb = n_ret;
    press(2, 2'b10);
    chk("step_first_stage", 32'(stage), 32'h0);
    tick();
    run_instr(5'd8, 0, 1'b0, 5'd0, 1'b0);
    chk("step_halt_mode", 32'(mode), 32'h3);
    chk("step_pc", 32'(pc), 32'h9);
    chk("step_stage", 32'(stage), 32'h0);
    repeat (6) tick();
    chk("step_one_retire", 32'(n_ret - rb), 32'h1);

    release_all();
    repeat (3) begin
      sw_run = 1'b1;
      repeat (DB - 1) tick();
      sw_run = 1'b0;
      repeat (2) tick();
    end
    repeat (DB + 6) tick();
    chk("bounce_mode", 32'(mode), 32'h3);

    press(1, 2'b01);
    chk("resume_pc", 32'(pc), 32'h9);
    tick();
    run_instr(5'd9, 0, 1'b0, 5'd0, 1'b0);
    chk("pre_abort_stage", 32'(stage), 32'h01);
    chk("pre_abort_pc", 32'(pc), 32'd10);
    rp_q.push_back(5'd10);
    tick();
    chk("abort_id", 32'(stage), 32'h02);
    sw_load = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_seq", 32'(stage), 32'(st_exp[k]));
      if (k == 3) chk("abort_next_pc", 32'(pc), 32'd11);
    end
    tick();
    chk("abort_mode", 32'(mode), 32'h0);
    chk("abort_stage", 32'(stage), 32'h0);
    chk("abort_pc", 32'(pc), 32'h0);
    chk("abort_load_done", 32'(load_done), 32'h0);

    release_all();
    rb = n_ret;
    sw_load = 1'b1;
    sw_run  = 1'b1;
    repeat (DB + 10) tick();
    chk("both_mode", 32'(mode), 32'h0);
    chk("both_stage", 32'(stage), 32'h0);
    chk("both_pc", 32'(pc), 32'h0);
    chk("both_no_retire", 32'(n_ret - rb), 32'h0);
    release_all();

    for (int i = 0; i < 33; i++) begin
      wa_q.push_back(5'(i % 32));
      wd_q.push_back(32'hC0DE_0000 + 32'(i));
      ld_valid = 1'b1;
      ld_data  = 32'hC0DE_0000 + 32'(i);
      ld_last  = (i == 32);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("wrap_load_done", 32'(load_done), 32'h1);
    repeat (2) tick();
    chk("wr_queue_empty", 32'(wa_q.size()), 32'h0);
    chk("ret_queue_empty", 32'(rp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the 32-entry single-issue core. It owns the LOAD/RUN/STEP/HALT operating mode and conditions the three push-buttons. In LOAD it writes a word stream into instruction memory. In RUN/STEP it drives a one-hot IF→ID→EX→MEM→WB stage sequence and the program counter, and the datapath executes under these stage enables.

## Interface
Parameters:
- ADDR_W, 5, instruction-memory address / pc width (32 entries)
- DB_CYCLES, 1000, consecutive stable cycles a synchronized button level needs before it is accepted

Ports:
- clk  in  1  system clock (single domain)
- rst_n  in  1  asynchronous, active-low reset
- sw_load  in  1  raw button, north; requests LOAD
- sw_run  in  1  raw button, south; requests RUN
- sw_step  in  1  raw button, east; requests single step
- ld_valid  in  1  loader word valid
- ld_data  in  32  loader word
- ld_last  in  1  qualifies the final loader word
- halt_req  in  1  decoder halt indication, sampled in ID
- br_taken  in  1  branch/jump taken, sampled in EX
- br_target  in  ADDR_W  branch/jump target, sampled in EX
- mem_ready  in  1  data memory ready; low stalls MEM
- imem_we  out  1  instruction-memory write enable
- imem_waddr  out  ADDR_W  instruction-memory write address
- imem_wdata  out  32  instruction-memory write data
- pc  out  ADDR_W  current instruction address
- stage  out  5  one-hot {WB,MEM,EX,ID,IF}; 0 when idle
- mode  out  2  00 LOAD, 01 RUN, 10 STEP, 11 HALT
- load_done  out  1  final word written since entering LOAD
- retire  out  1  high during each WB cycle

## Operation
- Button path: each button goes through a 2-FF synchronizer, then a debounce counter. The accepted level updates only after DB_CYCLES identical consecutive samples. An event is a 0→1 edge of the accepted level.
- Simultaneous events use the priority load > run > step.
- A load event in any mode → LOAD. The in-flight instruction is aborted, and stage, pc, the write pointer wptr, load_done, and the latched halt/branch state are cleared.
- LOAD:
  - stage = 0.
  - imem_we = ld_valid (combinational), imem_waddr = wptr, imem_wdata = ld_data.
  - Each accepted word increments wptr, wrapping from 2^ADDR_W−1 to 0.
  - ld_valid & ld_last sets load_done. Mode stays LOAD.
- Mode transitions:
  - Run event in LOAD, HALT or STEP → RUN. From LOAD, pc = 0. From HALT or STEP, pc is kept.
  - Step event in LOAD or HALT → STEP.
  - Run and step events in RUN are ignored. A step event in STEP is ignored.
  - ld_valid is ignored outside LOAD, and imem_we stays 0.
- Stage sequence (RUN/STEP):
  - IF→ID→EX→MEM→WB→IF, one cycle per stage.
  - MEM holds while mem_ready = 0 and advances in the cycle mem_ready = 1.
- EX latches br_taken/br_target.
- ID latches halt_req.
- At the end of WB:
  - pc ← br_target if the latched br_taken is set, else pc+1 modulo 2^ADDR_W.
  - If the latched halt is set, or mode = STEP, → HALT with stage = 0.
  - Otherwise the sequence continues with IF.
- Latched halt and branch state clears at every IF.
- In HALT, stage = 0 and pc holds.

## Timing
- Reset values: mode = LOAD, stage = 0, pc = 0, load_done = 0, wptr = 0, imem_we = 0, retire = 0; debounce and synchronizer state = 0.
- Button latency: 2 sync cycles + DB_CYCLES + 1 edge cycle, then mode changes on the following edge.
- The first IF is asserted the cycle after mode becomes RUN or STEP.
- Minimum instruction time is 5 cycles; each cycle with mem_ready = 0 in MEM adds one.
- The new pc is visible the cycle after WB, coincident with the next IF.
- retire = stage[4]. Exactly one retire per executed instruction.
- A load event arriving during WB takes priority: no pc update, and no transition to HALT.
- rst_n assertion clears all state asynchronously. Deassertion is synchronized inside the block.

## Test plan
- Reset, then a 3-word stream (ld_last on word 3) → writes at addresses 0,1,2 with matching data; load_done = 1; wptr wraps correctly after 32 words on a separate run.
- Run event, br_taken = 0, mem_ready = 1 → stage cycles 00001,00010,00100,01000,10000; pc 0→1→2 at 5-cycle spacing; retire every 5th cycle.
- mem_ready held low 3 cycles in MEM → MEM held 4 cycles, 8-cycle instruction, pc increments once.
- br_taken = 1, br_target = 7 in EX of the instruction at pc 2 → next IF has pc = 7; a later halt_req in ID → mode = 11 after WB, stage = 0, pc holds.
- From HALT, step event → exactly one retire, then HALT. A run event then resumes from the held pc. Button bounce shorter than DB_CYCLES produces no event.
- A load event mid-EX, and load + run asserted simultaneously → mode = LOAD, pc = 0, stage = 0, no retire.
